ws2812b_decoder: RTL and testbench

Single-wire WS2812B bitstream receiver. It measures the high-pulse widths on a serial line, recovers 24-bit GRB pixel words and presents them one pixel at a time with an address strobe. It also detects the latch (reset) gap that ends each frame. It is the receive end of the matrix output path: it sits on a loopback of the LED data pin, or on a second board, to check or mirror the frames the output controller transmits.

---
 rtl/ws2812b_decoder.sv | 210 +++++++++++++++++++++
 tb/tb_ws2812b_decoder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812b_decoder.sv
// WS2812B single-wire receiver: pulse-width decode into 24-bit GRB pixels plus latch-gap framing.
// Optional glitch filter on the conditioned line: define WS2812B_DECODER_GLITCH_FILTER_EN.
module ws2812b_decoder #(
  parameter int NUM_PIXELS           = 64,
  parameter int BIT_THRESHOLD_CYCLES = 7,
  parameter int MAX_HIGH_CYCLES      = 24,
  parameter int RESET_CYCLES         = 600
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_din,
  output logic [23:0] o_pixel_grb,
  output logic [5:0]  o_pixel_addr,
  output logic        o_pixel_valid,
  output logic        o_frame_done,
  output logic [6:0]  o_pixel_count,
  output logic        o_overflow,
  output logic        o_error
);

  localparam logic [9:0] THR_C  = 10'(BIT_THRESHOLD_CYCLES);
  localparam logic [9:0] MAXH_C = 10'(MAX_HIGH_CYCLES);
  localparam logic [9:0] GAP_C  = 10'(RESET_CYCLES);
  localparam logic [6:0] NPIX_C = 7'(NUM_PIXELS);

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    IDLE = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } state_t;

  logic sync1_q, sync2_q;
  logic din_f;
  logic lvl_q, rise_q, fall_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= i_din;
      sync2_q <= sync1_q;
    end
  end

`ifdef WS2812B_DECODER_GLITCH_FILTER_EN
  // The filtered level only follows the synchronizer after two agreeing samples.
  logic flt_a_q, flt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flt_a_q <= 1'b0;
      flt_q   <= 1'b0;
    end else begin
      flt_a_q <= sync2_q;
      if (sync2_q == flt_a_q) flt_q <= sync2_q;
    end
  end

  assign din_f = flt_q;
`else
  assign din_f = sync2_q;
`endif

  // Registered edge detect; lvl_q is the line level aligned with rise_q/fall_q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lvl_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      lvl_q  <= din_f;
      rise_q <= din_f & ~lvl_q;
      fall_q <= ~din_f & lvl_q;
    end
  end

  state_t      state_q;
  logic [9:0]  cnt_q;
  logic [4:0]  bit_cnt_q;
  logic [23:0] sr_q;
  logic [6:0]  pix_cnt_q;
  logic [23:0] pixel_grb_q;
  logic [5:0]  pixel_addr_q;
  logic        pixel_valid_q;
  logic        frame_done_q;
  logic [6:0]  pixel_count_q;
  logic        overflow_q;
  logic        error_q;

  logic [9:0]  cnt_d;
  logic        bit_d;
  logic [23:0] sr_d;
  logic        pix_ok;
  logic [6:0]  pix_cnt_d;

  assign cnt_d     = (cnt_q == 10'h3FF) ? cnt_q : cnt_q + 10'd1;
  assign bit_d     = (cnt_q >= THR_C);
  assign sr_d      = {sr_q[22:0], bit_d};
  assign pix_ok    = (pix_cnt_q < NPIX_C);
  assign pix_cnt_d = pix_cnt_q + 7'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= SYNC;
      cnt_q         <= '0;
      bit_cnt_q     <= '0;
      sr_q          <= '0;
      pix_cnt_q     <= '0;
      pixel_grb_q   <= '0;
      pixel_addr_q  <= '0;
      pixel_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
      pixel_count_q <= '0;
      overflow_q    <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      pixel_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
      error_q       <= 1'b0;
      // Frame results stay visible for the frame_done cycle, then clear.
      if (frame_done_q) begin
        overflow_q    <= 1'b0;
        pixel_count_q <= '0;
      end
      case (state_q)
        SYNC: begin
          if (lvl_q) begin
            cnt_q <= '0;
          end else if (cnt_d >= GAP_C) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        IDLE: begin
          cnt_q         <= '0;
          bit_cnt_q     <= '0;
          pix_cnt_q     <= '0;
          overflow_q    <= 1'b0;
          pixel_count_q <= '0;
          if (rise_q) begin
            state_q <= HIGH;
            cnt_q   <= 10'd1;
          end
        end
        HIGH: begin
          if (cnt_q > MAXH_C) begin
            error_q <= 1'b1;
            cnt_q   <= '0;
            state_q <= SYNC;
          end else if (fall_q) begin
            sr_q    <= sr_d;
            cnt_q   <= '0;
            state_q <= LOW;
            if (bit_cnt_q == 5'd23) begin
              bit_cnt_q <= '0;
              if (pix_ok) begin
                pixel_grb_q   <= sr_d;
                pixel_addr_q  <= pix_cnt_q[5:0];
                pixel_valid_q <= 1'b1;
                pix_cnt_q     <= pix_cnt_d;
                pixel_count_q <= pix_cnt_d;
              end else begin
                overflow_q <= 1'b1;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 5'd1;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        LOW: begin
          if (cnt_d >= GAP_C) begin
            // The gap wins over a coincident rise; that rise starts the next frame.
            frame_done_q <= 1'b1;
            error_q      <= (bit_cnt_q != 5'd0);
            bit_cnt_q    <= '0;
            pix_cnt_q    <= '0;
            if (rise_q) begin
              state_q <= HIGH;
              cnt_q   <= 10'd1;
            end else begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end
          end else if (rise_q) begin
            state_q <= HIGH;
            cnt_q   <= 10'd1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= SYNC;
      endcase
    end
  end

  assign o_pixel_grb   = pixel_grb_q;
  assign o_pixel_addr  = pixel_addr_q;
  assign o_pixel_valid = pixel_valid_q;
  assign o_frame_done  = frame_done_q;
  assign o_pixel_count = pixel_count_q;
  assign o_overflow    = overflow_q;
  assign o_error       = error_q;

endmodule

// File: tb/tb_ws2812b_decoder.sv
// Scoreboard bench for ws2812b_decoder: expected pixels/frames queued at drive time, checked on strobes.
module tb_ws2812b_decoder;

  localparam int T0H  = 5;
  localparam int T1H  = 10;
  localparam int TBIT = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din = 1'b0;
  logic [23:0] o_pixel_grb;
  logic [5:0]  o_pixel_addr;
  logic        o_pixel_valid;
  logic        o_frame_done;
  logic [6:0]  o_pixel_count;
  logic        o_overflow;
  logic        o_error;

  always #5 clk = ~clk;

  ws2812b_decoder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_din        (din),
    .o_pixel_grb  (o_pixel_grb),
    .o_pixel_addr (o_pixel_addr),
    .o_pixel_valid(o_pixel_valid),
    .o_frame_done (o_frame_done),
    .o_pixel_count(o_pixel_count),
    .o_overflow   (o_overflow),
    .o_error      (o_error)
  );

  typedef struct {
    logic [5:0]  addr;
    logic [23:0] grb;
  } pix_t;

  typedef struct {
    logic [6:0] cnt;
    logic       ovf;
  } frm_t;

  pix_t pix_q[$];
  frm_t frm_q[$];
  pix_t exp_p;
  frm_t exp_f;
  int   err_seen = 0;
  int   tests_run = 0;
  int   tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_pix(input logic [5:0] a, input logic [23:0] g);
    pix_t p;
    p.addr = a;
    p.grb  = g;
    pix_q.push_back(p);
  endtask

  task automatic push_frm(input logic [6:0] c, input logic ovf);
    frm_t f;
    f.cnt = c;
    f.ovf = ovf;
    frm_q.push_back(f);
  endtask

  task automatic send_bit(input logic b, input logic glitch);
    int hi;
    hi = b ? T1H : T0H;
    din = 1'b1;
    repeat (hi) @(negedge clk);
    din = 1'b0;
    if (glitch) begin
      repeat (4) @(negedge clk);
      din = 1'b1;
      @(negedge clk);
      din = 1'b0;
      repeat (TBIT - hi - 5) @(negedge clk);
    end else begin
      repeat (TBIT - hi) @(negedge clk);
    end
  endtask

  task automatic send_pixel(input logic [23:0] v);
    for (int i = 23; i >= 0; i--) send_bit(v[i], 1'b0);
  endtask

  task automatic gap();
    din = 1'b0;
    repeat (700) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_grb"},   o_pixel_grb,   0);
    check({pfx, "_addr"},  o_pixel_addr,  0);
    check({pfx, "_valid"}, o_pixel_valid, 0);
    check({pfx, "_done"},  o_frame_done,  0);
    check({pfx, "_count"}, o_pixel_count, 0);
    check({pfx, "_ovf"},   o_overflow,    0);
    check({pfx, "_err"},   o_error,       0);
  endtask

  task automatic check_drained(input string pfx);
    check({pfx, "_pix_left"}, pix_q.size(), 0);
    check({pfx, "_frm_left"}, frm_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_pixel_valid) begin
        $display("[TB] pixel addr=%0d grb=%06h", o_pixel_addr, o_pixel_grb);
        if (pix_q.size() == 0) begin
          check("unexp_valid", 1, 0);
        end else begin
          exp_p = pix_q.pop_front();
          check("pix_addr", o_pixel_addr, exp_p.addr);
          check("pix_grb", o_pixel_grb, exp_p.grb);
        end
      end
      if (o_frame_done) begin
        $display("[TB] frame count=%0d overflow=%0d", o_pixel_count, o_overflow);
        if (frm_q.size() == 0) begin
          check("unexp_frame", 1, 0);
        end else begin
          exp_f = frm_q.pop_front();
          check("frm_count", o_pixel_count, exp_f.cnt);
          check("frm_ovf", o_overflow, exp_f.ovf);
        end
      end
      if (o_error) begin
        $display("[TB] error strobe");
        err_seen++;
      end
    end
  end

  initial begin
    int e0;
    logic [23:0] v;
    logic [24:0] ext;

    rst_n = 1'b0;
    din   = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    gap();

    // Single pixel, then latch gap
    e0 = err_seen;
    push_pix(6'd0, 24'h00FF00);
    push_frm(7'd1, 1'b0);
    send_pixel(24'h00FF00);
    gap();
    check_drained("t1");
    check("t1_err", err_seen - e0, 0);

    // Full frame of 64 pixels
    e0 = err_seen;
    for (int i = 0; i < 64; i++) begin
      push_pix(6'(i), 24'h010203 + 24'(i));
      send_pixel(24'h010203 + 24'(i));
    end
    push_frm(7'd64, 1'b0);
    gap();
    check_drained("t2");
    check("t2_err", err_seen - e0, 0);

    // 65 pixels: last one dropped, overflow set then cleared by next IDLE
    e0 = err_seen;
    for (int i = 0; i < 64; i++) begin
      push_pix(6'(i), 24'hA00000 ^ 24'(i * 3));
      send_pixel(24'hA00000 ^ 24'(i * 3));
    end
    repeat (3) @(negedge clk);
    check("t3_ovf_early", o_overflow, 0);
    push_frm(7'd64, 1'b1);
    send_pixel(24'h777777);
    repeat (3) @(negedge clk);
    check("t3_ovf_set", o_overflow, 1);
    gap();
    check("t3_ovf_clr", o_overflow, 0);
    check_drained("t3");
    check("t3_err", err_seen - e0, 0);

    // 12 bits only: partial pixel discarded with an error
    e0 = err_seen;
    push_frm(7'd0, 1'b0);
    for (int i = 0; i < 12; i++) send_bit(i[0], 1'b0);
    gap();
    check_drained("t4");
    check("t4_err", err_seen - e0, 1);

    // Over-long high pulse mid-pixel, then a pixel sent before resync is ignored
    e0 = err_seen;
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    din = 1'b1;
    repeat (30) @(negedge clk);
    din = 1'b0;
    repeat (100) @(negedge clk);
    send_pixel(24'hABCDEF);
    gap();
    check_drained("t5a");
    check("t5_err", err_seen - e0, 1);
    push_pix(6'd0, 24'h123456);
    push_frm(7'd1, 1'b0);
    send_pixel(24'h123456);
    gap();
    check_drained("t5b");

    // Reset after 10 pixels aborts the frame silently
    for (int i = 0; i < 10; i++) begin
      push_pix(6'(i), 24'h0F0F00 + 24'(i));
      send_pixel(24'h0F0F00 + 24'(i));
    end
    repeat (3) @(negedge clk);
    check("t6_pre_count", o_pixel_count, 10);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("t6");
    rst_n = 1'b1;
    check("t6_pix_left", pix_q.size(), 0);
    gap();
    e0 = err_seen;
    push_pix(6'd0, 24'hC0FFEE);
    push_frm(7'd1, 1'b0);
    send_pixel(24'hC0FFEE);
    gap();
    check_drained("t6");
    check("t6_err", err_seen - e0, 0);

    // One-cycle glitch in the low phase of the first (zero) bit
    e0 = err_seen;
    v = 24'h5A5A5A;
`ifdef WS2812B_DECODER_GLITCH_FILTER_EN
    push_pix(6'd0, v);
    push_frm(7'd1, 1'b0);
`else
    ext = {v[23], 1'b0, v[22:0]};
    push_pix(6'd0, ext[24:1]);
    push_frm(7'd1, 1'b0);
`endif
    send_bit(v[23], 1'b1);
    for (int i = 22; i >= 0; i--) send_bit(v[i], 1'b0);
    gap();
    check_drained("t7");
`ifdef WS2812B_DECODER_GLITCH_FILTER_EN
    check("t7_err", err_seen - e0, 0);
`else
    check("t7_err", err_seen - e0, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
